// File: rtl/heartbeat_gen.sv
// Heartbeat generator: issues a single-cycle beat to a downstream watchdog each
// period while the host proves liveness, and escalates to FAULT after repeated misses.
module heartbeat_gen #(
  parameter int unsigned CLK_FREQ       = 100000000,
  parameter int unsigned BEAT_PERIOD_MS = 1000,
  parameter int unsigned MAX_MISSED     = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        host_alive,
  input  logic        fault_clr,
  input  logic        wd_warning,
  input  logic        wd_triggered,
  output logic        heartbeat,
  output logic [1:0]  state,
  output logic [15:0] beat_count,
  output logic [7:0]  missed_count,
  output logic        fault
);

  // 64-bit product so large clock/period combinations cannot overflow
  localparam longint      PERIOD_CYCLES = (longint'(CLK_FREQ) * longint'(BEAT_PERIOD_MS)) / 1000;
  localparam logic [31:0] LAST_COUNT    = 32'(PERIOD_CYCLES - 1);
  localparam logic [7:0]  MISS_LIMIT    = 8'(MAX_MISSED);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        alive_q, alive_d;
  logic        hb_d;
  logic [15:0] beat_d;
  logic [7:0]  missed_d;
  logic [7:0]  missed_inc;
  logic        boundary;
  logic        live_now;

  assign boundary   = (cnt_q == LAST_COUNT);
  assign live_now   = alive_q | host_alive;
  assign missed_inc = (missed_count == 8'hFF) ? missed_count : missed_count + 8'd1;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alive_q      <= 1'b0;
      heartbeat    <= 1'b0;
      beat_count   <= '0;
      missed_count <= '0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alive_q      <= alive_d;
      heartbeat    <= hb_d;
      beat_count   <= beat_d;
      missed_count <= missed_d;
      fault        <= (state_d == FAULT);
    end
  end

  // Branch order encodes priority: !enable, fault_clr, wd_triggered, boundary, early beat
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alive_d  = alive_q;
    hb_d     = 1'b0;
    beat_d   = beat_count;
    missed_d = missed_count;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      alive_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = RUN;
          cnt_d    = '0;
          missed_d = '0;
          alive_d  = host_alive;
        end
        FAULT: begin
          cnt_d   = '0;
          alive_d = 1'b0;
          if (fault_clr) begin
            state_d  = RUN;
            missed_d = '0;
          end
        end
        default: begin
          if (wd_triggered) begin
            state_d = FAULT;
            cnt_d   = '0;
            alive_d = 1'b0;
          end else if (boundary) begin
            cnt_d   = '0;
            alive_d = 1'b0;
            if (live_now) begin
              hb_d     = 1'b1;
              beat_d   = beat_count + 16'd1;
              missed_d = '0;
              state_d  = RUN;
            end else begin
              missed_d = missed_inc;
              state_d  = (missed_inc >= MISS_LIMIT) ? FAULT : STARVED;
            end
          end else if ((state_q == RUN) && wd_warning && alive_q && !heartbeat) begin
            // Watchdog is close to expiring: beat now and restart the period
            hb_d    = 1'b1;
            cnt_d   = '0;
            beat_d  = beat_count + 16'd1;
            alive_d = 1'b0;
          end else begin
            cnt_d   = cnt_q + 32'd1;
            alive_d = live_now;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heartbeat_gen.sv
// Randomised scoreboard bench for heartbeat_gen: a timestamp-based reference model
// predicts each cycle's outputs, and a separate monitor compares them against the DUT.
module tb_heartbeat_gen;

  localparam int P      = 4;
  localparam int MAXM   = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_STARVED = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        host_alive = 1'b0;
  logic        fault_clr = 1'b0;
  logic        wd_warning = 1'b0;
  logic        wd_triggered = 1'b0;
  logic        heartbeat;
  logic [1:0]  state;
  logic [15:0] beat_count;
  logic [7:0]  missed_count;
  logic        fault;

  typedef struct {
    logic        hb;
    logic [1:0]  st;
    logic [15:0] bc;
    logic [7:0]  mc;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  // Reference model: the period is tracked as the absolute cycle it began at
  int cyc = 0;
  int origin = 0;
  int mode = M_IDLE;
  bit live = 0;
  bit hb = 0;
  int beats = 0;
  int missed = 0;

  heartbeat_gen #(
    .CLK_FREQ(1000),
    .BEAT_PERIOD_MS(4),
    .MAX_MISSED(MAXM)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .enable(enable),
    .host_alive(host_alive),
    .fault_clr(fault_clr),
    .wd_warning(wd_warning),
    .wd_triggered(wd_triggered),
    .heartbeat(heartbeat),
    .state(state),
    .beat_count(beat_count),
    .missed_count(missed_count),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic void modelStep(input bit r, input bit e, input bit ha,
                                    input bit fc, input bit ww, input bit wt);
    bit was_hb;
    was_hb = hb;
    hb = 0;
    if (!r) begin
      mode = M_IDLE; beats = 0; missed = 0; live = 0; origin = cyc + 1;
    end else if (!e) begin
      mode = M_IDLE; live = 0; origin = cyc + 1;
    end else if (mode == M_IDLE) begin
      mode = M_RUN; origin = cyc + 1; missed = 0; live = ha;
    end else if (mode == M_FAULT) begin
      live = 0; origin = cyc + 1;
      if (fc) begin
        mode = M_RUN; missed = 0;
      end
    end else if (wt) begin
      mode = M_FAULT; live = 0; origin = cyc + 1;
    end else if (cyc - origin == P - 1) begin
      origin = cyc + 1;
      if (live || ha) begin
        hb = 1; beats = (beats + 1) % 65536; missed = 0; mode = M_RUN; live = 0;
      end else begin
        missed = (missed < 255) ? missed + 1 : 255;
        mode = (missed >= MAXM) ? M_FAULT : M_STARVED;
      end
    end else if (mode == M_RUN && ww && live && !was_hb) begin
      hb = 1; beats = (beats + 1) % 65536; origin = cyc + 1; live = 0;
    end else begin
      live = live | ha;
    end
    cyc++;
  endfunction

  task automatic applyStimulus(input bit r, input bit e, input bit ha,
                               input bit fc, input bit ww, input bit wt);
    exp_t x;
    @(negedge clk);
    rstn = r; enable = e; host_alive = ha;
    fault_clr = fc; wd_warning = ww; wd_triggered = wt;
    modelStep(r, e, ha, fc, ww, wt);
    x.hb = hb;
    x.st = 2'(mode);
    x.bc = 16'(beats);
    x.mc = 8'(missed);
    x.f  = (mode == M_FAULT);
    exp_q.push_back(x);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: compares once per cycle, #1 after the active edge
  initial begin : monitor
    exp_t e;
    logic prev_hb;
    prev_hb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("heartbeat", 16'(heartbeat), 16'(e.hb));
        checkOutput("state", 16'(state), 16'(e.st));
        checkOutput("beat_count", beat_count, e.bc);
        checkOutput("missed_count", 16'(missed_count), 16'(e.mc));
        checkOutput("fault", 16'(fault), 16'(e.f));
        checkOutput("hb_not_back_to_back", 16'(prev_hb & heartbeat), 16'd0);
        prev_hb = heartbeat;
      end
    end
  end

  initial begin : driver
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    // Steady host pulses every period
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, (i % 4) == 1, 0, 0, 0);
    // Silence until starvation escalates to FAULT
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    // Clear the fault, host_alive ignored during FAULT then restores beats
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, (i % 4) == 0, 0, 0, 0);
    // Early beats under watchdog warning, including a deferred one after a beat
    for (int i = 0; i < 14; i++) applyStimulus(1, 1, (i == 1) || (i == 6) || (i == 7), 0, i >= 2, 0);
    // Liveness on a boundary, then silence, then a watchdog trip
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, (i % 3) == 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    // fault_clr outside FAULT, enable drop mid-period, reset mid-period
    applyStimulus(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, i == 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, i == 2, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0, 0, 0);
    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(199) != 0,
                    $urandom_range(79) != 0,
                    $urandom_range(4) == 0,
                    $urandom_range(9) == 0,
                    $urandom_range(3) == 0,
                    $urandom_range(49) == 0);
    end
    stim_done = 1;
  end

  initial begin : finisher
    int guard;
    wait (stim_done);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    if (n_checks < 12) begin
      n_fail++;
      $display("[TB] FAIL check_count: got %0d, expected at least 12", n_checks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog_timeout
    #2000000;
    $display("[TB] FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
